// File: rtl/ml_engine_rf.sv
// ml_engine_rf: picks a memory maintenance action (0 NONE, 1 SCRUB, 2 REFRESH)
// from a DRAM error-statistics snapshot. Hard rules take priority; otherwise
// a fixed five-tree forest votes. The decision is registered once per clock.
module ml_engine_rf #(
   parameter int unsigned ROW_HAMMER_TH  = 64,
   parameter int unsigned ROW_RATIO_MULT = 5,
   parameter int unsigned RATE_TH        = 50,
   parameter int unsigned COL_TH         = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] total_errors,
   input  logic [15:0] read_errors,
   input  logic [15:0] write_errors,
   input  logic [15:0] scrub_errors,
   input  logic [15:0] unique_rows,
   input  logic [15:0] unique_cols,
   input  logic [15:0] max_row_hits,
   input  logic [15:0] max_col_hits,
   input  logic [15:0] error_rate_int,
   output logic [1:0]  final_action
);

   localparam int unsigned CW = 3;   // vote counter width (up to 5 votes)

   localparam logic [1:0] ACT_NONE    = 2'd0;
   localparam logic [1:0] ACT_SCRUB   = 2'd1;
   localparam logic [1:0] ACT_REFRESH = 2'd2;

   logic [1:0]    action_d, action_q;
   logic [18:0]   row_scaled;
   logic [16:0]   rw_sum;
   logic          rule_hammer, rule_ratio, rule_refresh;
   logic [1:0]    vote_a, vote_b, vote_c, vote_d, vote_e;
   logic [CW-1:0] cnt_none, cnt_scrub, cnt_refresh;
   logic [1:0]    forest_action;

   // Widened arithmetic so neither product nor sum can wrap
   assign row_scaled = 19'(unique_rows) * 19'(ROW_RATIO_MULT);
   assign rw_sum     = 17'(read_errors) + 17'(write_errors);

   // Hard rules
   assign rule_hammer  = (max_row_hits >= 16'(ROW_HAMMER_TH));
   assign rule_ratio   = (row_scaled < 19'(total_errors));
   assign rule_refresh = (error_rate_int >= 16'(RATE_TH)) &&
                         (unique_cols >= 16'(COL_TH));

   // Individual tree votes
   always_comb begin
      vote_a = ACT_NONE;
      vote_b = ACT_NONE;
      vote_c = ACT_NONE;
      vote_d = ACT_NONE;
      vote_e = ACT_NONE;

      if (max_row_hits >= 16'd32) begin
         vote_a = (max_col_hits < 16'd16) ? ACT_SCRUB : ACT_REFRESH;
      end else begin
         vote_a = (error_rate_int >= 16'd100) ? ACT_REFRESH : ACT_NONE;
      end

      if (total_errors >= 16'd200) begin
         vote_b = (unique_rows <= 16'd16) ? ACT_SCRUB : ACT_REFRESH;
      end else begin
         vote_b = (17'(scrub_errors) > rw_sum) ? ACT_SCRUB : ACT_NONE;
      end

      if ((unique_cols >= 16'd16) || (max_col_hits >= 16'd32)) begin
         vote_c = ACT_REFRESH;
      end

      if (error_rate_int >= 16'd80) begin
         vote_d = (unique_cols >= 16'd4) ? ACT_REFRESH : ACT_SCRUB;
      end

      if ((max_row_hits >= 16'd16) && (unique_rows <= 16'd8)) begin
         vote_e = ACT_SCRUB;
      end else if (unique_cols >= 16'd8) begin
         vote_e = ACT_REFRESH;
      end
   end

   // Majority vote; ties resolve toward the more severe action
   always_comb begin
      cnt_none    = CW'(vote_a == ACT_NONE)    + CW'(vote_b == ACT_NONE)    +
                    CW'(vote_c == ACT_NONE)    + CW'(vote_d == ACT_NONE)    +
                    CW'(vote_e == ACT_NONE);
      cnt_scrub   = CW'(vote_a == ACT_SCRUB)   + CW'(vote_b == ACT_SCRUB)   +
                    CW'(vote_c == ACT_SCRUB)   + CW'(vote_d == ACT_SCRUB)   +
                    CW'(vote_e == ACT_SCRUB);
      cnt_refresh = CW'(vote_a == ACT_REFRESH) + CW'(vote_b == ACT_REFRESH) +
                    CW'(vote_c == ACT_REFRESH) + CW'(vote_d == ACT_REFRESH) +
                    CW'(vote_e == ACT_REFRESH);
      if ((cnt_refresh >= cnt_scrub) && (cnt_refresh >= cnt_none)) begin
         forest_action = ACT_REFRESH;
      end else if (cnt_scrub >= cnt_none) begin
         forest_action = ACT_SCRUB;
      end else begin
         forest_action = ACT_NONE;
      end
   end

   // Priority select: hard rules first, forest last
   always_comb begin
      action_d = forest_action;
      if (rule_hammer || rule_ratio) begin
         action_d = ACT_SCRUB;
      end else if (rule_refresh) begin
         action_d = ACT_REFRESH;
      end
   end

   // Decision register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         action_q <= ACT_NONE;
      end else begin
         action_q <= action_d;
      end
   end

   assign final_action = action_q;

endmodule

// File: tb/tb_ml_engine_rf.sv
// Scoreboard bench for ml_engine_rf: driver pushes model results into a queue,
// a monitor pops and compares one cycle after each vector is captured.
module tb_ml_engine_rf;

   typedef struct packed {
      logic [15:0] total;
      logic [15:0] rd;
      logic [15:0] wr;
      logic [15:0] scrub;
      logic [15:0] rows;
      logic [15:0] cols;
      logic [15:0] mrh;
      logic [15:0] mch;
      logic [15:0] rate;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] total_errors, read_errors, write_errors, scrub_errors;
   logic [15:0] unique_rows, unique_cols, max_row_hits, max_col_hits;
   logic [15:0] error_rate_int;
   logic [1:0]  final_action;

   int          checks   = 0;
   int          failures = 0;
   logic [1:0]  exp_q[$];
   logic [1:0]  last_exp;

   ml_engine_rf dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .total_errors  (total_errors),
      .read_errors   (read_errors),
      .write_errors  (write_errors),
      .scrub_errors  (scrub_errors),
      .unique_rows   (unique_rows),
      .unique_cols   (unique_cols),
      .max_row_hits  (max_row_hits),
      .max_col_hits  (max_col_hits),
      .error_rate_int(error_rate_int),
      .final_action  (final_action)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference decision computed from the rules with plain integer arithmetic
   function automatic logic [1:0] model(input vec_t v);
      int unsigned total = v.total, rd = v.rd, wr = v.wr, scrub = v.scrub;
      int unsigned rows = v.rows, cols = v.cols, mrh = v.mrh, mch = v.mch;
      int unsigned rate = v.rate;
      int unsigned votes[5];
      int          cnt[3];
      int          best;
      if (mrh >= 64) return 2'd1;
      if (rows * 5 < total) return 2'd1;
      if (rate >= 50 && cols >= 8) return 2'd2;
      votes[0] = (mrh >= 32) ? ((mch < 16) ? 1 : 2) : ((rate >= 100) ? 2 : 0);
      votes[1] = (total >= 200) ? ((rows <= 16) ? 1 : 2) : ((scrub > rd + wr) ? 1 : 0);
      votes[2] = (cols >= 16 || mch >= 32) ? 2 : 0;
      votes[3] = (rate >= 80) ? ((cols >= 4) ? 2 : 1) : 0;
      votes[4] = (mrh >= 16 && rows <= 8) ? 1 : ((cols >= 8) ? 2 : 0);
      cnt = '{0, 0, 0};
      foreach (votes[i]) cnt[votes[i]]++;
      best = 2;
      if (cnt[1] > cnt[best]) best = 1;
      if (cnt[0] > cnt[best]) best = 0;
      return 2'(best);
   endfunction

   function automatic vec_t mk(input int t, r, w, s, ur, uc, mr, mc, er);
      vec_t v;
      v.total = 16'(t);  v.rd  = 16'(r);  v.wr  = 16'(w);
      v.scrub = 16'(s);  v.rows = 16'(ur); v.cols = 16'(uc);
      v.mrh   = 16'(mr); v.mch = 16'(mc); v.rate = 16'(er);
      return v;
   endfunction

   function automatic logic [15:0] rfield();
      case ($urandom_range(0, 3))
         0:       return 16'($urandom);
         1:       return 16'($urandom_range(0, 20));
         2:       return 16'($urandom_range(0, 120));
         default: return 16'($urandom_range(0, 300));
      endcase
   endfunction

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Apply a vector mid-cycle; output must still hold the previous decision
   task automatic apply(input vec_t v);
      total_errors = v.total;  read_errors  = v.rd;   write_errors   = v.wr;
      scrub_errors = v.scrub;  unique_rows  = v.rows; unique_cols    = v.cols;
      max_row_hits = v.mrh;    max_col_hits = v.mch;  error_rate_int = v.rate;
      #1;
      chk("hold_before_edge", final_action, last_exp);
      last_exp = model(v);
      exp_q.push_back(last_exp);
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      apply(v);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: pending=%0d expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: compare the registered action one step after each capture edge
   initial begin
      logic [1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("action", final_action, e);
         end
      end
   end

   // Stimulus
   initial begin
      rst_n    = 1'b0;
      last_exp = 2'd0;
      total_errors = '0; read_errors  = '0; write_errors   = '0;
      scrub_errors = '0; unique_rows  = '0; unique_cols    = '0;
      max_row_hits = '0; max_col_hits = '0; error_rate_int = '0;
      #3;
      chk("reset_async", final_action, 2'd0);
      @(posedge clk); #1;
      chk("reset_hold", final_action, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Directed rule edges and forest cases
      drive(mk(64, 0, 0, 0, 10, 5, 64, 5, 10));           // rule 1a at threshold
      drive(mk(64, 0, 0, 0, 10, 5, 63, 5, 10));           // just below hammer
      drive(mk(51, 0, 0, 0, 10, 5, 10, 5, 10));           // ratio 50 < 51
      drive(mk(50, 0, 0, 0, 10, 5, 10, 5, 10));           // ratio equality misses
      drive(mk(100, 0, 0, 0, 50, 8, 5, 5, 50));           // rule 2 at both edges
      drive(mk(100, 0, 0, 0, 50, 8, 5, 5, 49));           // rate just below
      drive(mk(100, 0, 0, 0, 50, 7, 5, 5, 150));          // forest 0 wins 3-2
      drive(mk(15, 5, 5, 5, 4, 4, 3, 3, 20));             // forest all none
      drive(mk(30, 5, 5, 20, 8, 2, 40, 4, 10));           // forest scrub 3 votes
      drive(mk(2000, 0, 0, 0, 13312, 0, 0, 0, 0));        // product must not wrap
      drive(mk(0, 32768, 32768, 1, 0, 0, 0, 0, 0));       // sum must not wrap
      drive(mk(65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535));
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      drain();

      // Randomized back-to-back vectors
      for (int i = 0; i < 300; i++) begin
         vec_t v;
         v.total = rfield(); v.rd   = rfield(); v.wr   = rfield();
         v.scrub = rfield(); v.rows = rfield(); v.cols = rfield();
         v.mrh   = rfield(); v.mch  = rfield(); v.rate = rfield();
         drive(v);
      end
      drain();

      // Mid-run reset with a SCRUB decision held
      drive(mk(64, 0, 0, 0, 10, 5, 64, 5, 10));
      drain();
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_midrun_async", final_action, 2'd0);
      @(posedge clk); #1;
      chk("reset_midrun_hold", final_action, 2'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      last_exp = 2'd0;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      drive(mk(100, 0, 0, 0, 50, 8, 5, 5, 50));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ml_engine_rf.md
Name: ml_engine_rf

Overview:
- Failure-prediction decision engine for the PredictRAM memory-health path.
- Takes a snapshot of DRAM error statistics and selects a maintenance action: 0 = NONE, 1 = SCRUB, 2 = REFRESH.
- Fixed hard rules take priority. If none fires, a fixed 5-tree random-forest majority vote decides.
- The result is registered, so downstream controllers see a stable action one cycle after the statistics are presented.

Parameters:
- ROW_HAMMER_TH, 64: max_row_hits at or above this value forces SCRUB.
- ROW_RATIO_MULT, 5: SCRUB fires when unique_rows*ROW_RATIO_MULT < total_errors.
- RATE_TH, 50: error_rate_int threshold for the REFRESH rule.
- COL_TH, 8: unique_cols threshold for the REFRESH rule.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- total_errors  in  16  total error count in the window.
- read_errors  in  16  errors detected on reads.
- write_errors  in  16  errors detected on writes.
- scrub_errors  in  16  errors found by the scrubber.
- unique_rows  in  16  distinct rows with errors.
- unique_cols  in  16  distinct columns with errors.
- max_row_hits  in  16  highest per-row error count.
- max_col_hits  in  16  highest per-column error count.
- error_rate_int  in  16  integer error rate.
- final_action  out  2  0 = NONE, 1 = SCRUB, 2 = REFRESH; 3 is never driven.

Behaviour:
- Reset: final_action = 0 immediately when rst_n goes low, and it stays 0 while rst_n is low.
- Reset timing: the first decision is captured on the first rising clk edge after rst_n deasserts.
- Latency: combinational decision on the current inputs, registered on every rising clk edge. Output reflects inputs from the previous edge. No handshake; inputs are sampled every cycle.
- All comparisons are unsigned.
- unique_rows*ROW_RATIO_MULT is computed at 19 bits. read_errors+write_errors is computed at 17 bits. No overflow or wrap is allowed in either.
- Priority, first match wins:
  1. Rule 1a: max_row_hits >= ROW_HAMMER_TH -> 1.
  2. Rule 1b: unique_rows*ROW_RATIO_MULT < total_errors (strict) -> 1.
  3. Rule 2: error_rate_int >= RATE_TH AND unique_cols >= COL_TH -> 2.
  4. Otherwise the forest vote decides.
- Forest trees (each tree emits one vote in {0,1,2}):
  - Tree A: if max_row_hits >= 32, then (max_col_hits < 16 ? 1 : 2); else (error_rate_int >= 100 ? 2 : 0).
  - Tree B: if total_errors >= 200, then (unique_rows <= 16 ? 1 : 2); else (scrub_errors > read_errors+write_errors ? 1 : 0).
  - Tree C: if unique_cols >= 16 -> 2; else if max_col_hits >= 32 -> 2; else 0.
  - Tree D: if error_rate_int >= 80, then (unique_cols >= 4 ? 2 : 1); else 0.
  - Tree E: if max_row_hits >= 16 AND unique_rows <= 8 -> 1; else if unique_cols >= 8 -> 2; else 0.
- Vote: count the votes per class; the class with the most votes wins. Ties go to the more severe action (2 over 1 over 0).
- Forest thresholds are fixed constants, not parameters.
- Boundaries:
  - Equality at ROW_HAMMER_TH, RATE_TH or COL_TH satisfies the rule.
  - Equality in the ratio rule does not fire it.
  - All-zero inputs give 0.
  - All-0xFFFF inputs give 1 via Rule 1a.
- Reset mid-operation: the output clears asynchronously. No other state exists.

Test Plan:
- Reset, then all inputs 0 -> final_action 0. Assert rst_n low mid-run with a non-zero action -> output drops to 0 without a clock edge.
- Rule 1 edges:
  - total=64, rows=10, cols=5, mrh=64, mch=5, rate=10, others 0 -> 1.
  - total=51, rows=10, cols=5, mrh=10, mch=5, rate=10 -> 1 (50 < 51).
  - Same but total=50 -> 0 (ratio rule misses; all trees vote 0).
- Rule 2 edge:
  - total=100, rows=50, cols=8, mrh=5, mch=5, rate=50 -> 2.
  - Same but cols=7, rate=150 -> 0 (votes A=2, D=2, B=C=E=0; 0 wins 3-2).
- ML decisions:
  - total=15, r=w=s=5, rows=4, cols=4, mrh=3, mch=3, rate=20 -> 0.
  - total=30, r=5, w=5, s=20, rows=8, cols=2, mrh=40, mch=4, rate=10 -> 1 (A, B, E vote 1).
- Latency: change inputs between edges -> output changes exactly one rising edge later. Back-to-back distinct vectors produce a matching pipelined output sequence.
